// File: rtl/secret_code_ctrl_pkg.sv
// Shared types and constants for the secret-code generator and code legality checks.
`default_nettype none

package secret_code_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 3;
  localparam int CODE_W     = NUM_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Digit order is {secret3, secret2, secret1, secret0}
  localparam logic [CODE_W-1:0] FALLBACK_NO_REPEAT = {3'd3, 3'd2, 3'd1, 3'd0};

endpackage

`default_nettype wire

// File: rtl/code_legal_chk.sv
// Combinational legality check of a four-digit code: range per digit, optional distinctness.
`default_nettype none

module code_legal_chk
  import secret_code_ctrl_pkg::*;
#(
  parameter int NUM_COLORS   = 6,
  parameter bit ALLOW_REPEAT = 1'b1
) (
  input  logic [CODE_W-1:0] candidate,
  output logic              legal
);

  localparam int NC_W = DIGIT_W + 1;
  localparam logic [NC_W-1:0] NC = NC_W'(NUM_COLORS);

  logic [DIGIT_W-1:0]    digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] in_range;
  logic                  dup;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign digit[i]    = candidate[i*DIGIT_W +: DIGIT_W];
    assign in_range[i] = {1'b0, digit[i]} < NC;
  end

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (digit[i] == digit[j]) dup = 1'b1;
      end
    end
  end

  assign legal = (&in_range) && (ALLOW_REPEAT || !dup);

endmodule

`default_nettype wire

// File: rtl/secret_code_ctrl.sv
// Draws PRNG digits until a legal secret code is found, committing a fallback after MAX_TRIES.
`default_nettype none

module secret_code_ctrl
  import secret_code_ctrl_pkg::*;
#(
  parameter int NUM_COLORS   = 6,
  parameter int MAX_TRIES    = 15,
  parameter bit ALLOW_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic [2:0] prng_code0,
  input  logic [2:0] prng_code1,
  input  logic [2:0] prng_code2,
  input  logic [2:0] prng_code3,
  output logic [2:0] secret0,
  output logic [2:0] secret1,
  output logic [2:0] secret2,
  output logic [2:0] secret3,
  output logic       ready,
  output logic       busy,
  output logic [3:0] draws,
  output logic       fallback
);

  localparam int NC_W = DIGIT_W + 1;
  localparam logic [NC_W-1:0] NC    = NC_W'(NUM_COLORS);
  localparam logic [3:0]      MAX_T = 4'(MAX_TRIES);

  state_t              state;
  logic [CODE_W-1:0]   candidate;
  logic [CODE_W-1:0]   folded;
  logic [CODE_W-1:0]   fallback_code;
  logic                legal;

  code_legal_chk #(
    .NUM_COLORS  (NUM_COLORS),
    .ALLOW_REPEAT(ALLOW_REPEAT)
  ) u_chk (
    .candidate(candidate),
    .legal    (legal)
  );

  // A single subtraction folds 0..7 into range because NUM_COLORS is at least 4
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_fold
    logic [DIGIT_W-1:0] d;
    assign d = candidate[i*DIGIT_W +: DIGIT_W];
    assign folded[i*DIGIT_W +: DIGIT_W] =
      ({1'b0, d} >= NC) ? (d - NC[DIGIT_W-1:0]) : d;
  end

  assign fallback_code = ALLOW_REPEAT ? folded : FALLBACK_NO_REPEAT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      candidate <= '0;
      secret0   <= '0;
      secret1   <= '0;
      secret2   <= '0;
      secret3   <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      draws     <= '0;
      fallback  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (new_game) begin
            state    <= DRAW;
            busy     <= 1'b1;
            ready    <= 1'b0;
            draws    <= '0;
            fallback <= 1'b0;
          end
        end
        DRAW: begin
          candidate <= {prng_code3, prng_code2, prng_code1, prng_code0};
          draws     <= draws + 4'd1;
          state     <= CHECK;
        end
        CHECK: begin
          if (legal) begin
            {secret3, secret2, secret1, secret0} <= candidate;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (draws < MAX_T) begin
            state <= DRAW;
          end else begin
            {secret3, secret2, secret1, secret0} <= fallback_code;
            fallback <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_secret_code_ctrl.sv
// Self-checking bench: default instance and a no-repeat instance driven from shared stimulus.
`default_nettype none

module tb_secret_code_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_game;
  logic [2:0] p0, p1, p2, p3;

  logic [2:0] d_s0, d_s1, d_s2, d_s3, n_s0, n_s1, n_s2, n_s3;
  logic       d_ready, d_busy, d_fb, n_ready, n_busy, n_fb;
  logic [3:0] d_draws, n_draws;

  secret_code_ctrl dut_d (
    .clk(clk), .rst(rst), .new_game(new_game),
    .prng_code0(p0), .prng_code1(p1), .prng_code2(p2), .prng_code3(p3),
    .secret0(d_s0), .secret1(d_s1), .secret2(d_s2), .secret3(d_s3),
    .ready(d_ready), .busy(d_busy), .draws(d_draws), .fallback(d_fb)
  );

  secret_code_ctrl #(.NUM_COLORS(6), .MAX_TRIES(15), .ALLOW_REPEAT(1'b0)) dut_n (
    .clk(clk), .rst(rst), .new_game(new_game),
    .prng_code0(p0), .prng_code1(p1), .prng_code2(p2), .prng_code3(p3),
    .secret0(n_s0), .secret1(n_s1), .secret2(n_s2), .secret3(n_s3),
    .ready(n_ready), .busy(n_busy), .draws(n_draws), .fallback(n_fb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [11:0] sec;
    logic [3:0]  draws;
    logic        fb;
  } exp_t;

  exp_t q_d[$];
  exp_t q_n[$];

  typedef struct {
    logic [11:0] code;
    logic [11:0] d_sec;
    logic [3:0]  d_dr;
    logic        d_fb;
    logic [11:0] n_sec;
    logic [3:0]  n_dr;
    logic        n_fb;
  } vec_t;

  function automatic logic [11:0] c4(input int a3, input int a2, input int a1, input int a0);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input string who, input bit have, input exp_t e,
                       input logic [11:0] sec, input logic [3:0] dr, input logic fb);
    if (!have) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_unexpected_commit: got commit at cycle %0d expected none", who, cyc);
    end else begin
      chk({who, "_latency"}, cyc, e.cyc);
      chk({who, "_secret"}, {20'd0, sec}, {20'd0, e.sec});
      chk({who, "_draws"}, {28'd0, dr}, {28'd0, e.draws});
      chk({who, "_fallback"}, {31'd0, fb}, {31'd0, e.fb});
    end
  endtask

  // Commit detection on the rising edge of ready
  logic d_rq = 1'b0, n_rq = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      d_rq <= 1'b0;
      n_rq <= 1'b0;
    end else begin
      d_rq <= d_ready;
      n_rq <= n_ready;
      if (d_ready && !d_rq) begin
        if (q_d.size() > 0) score("dflt", 1'b1, q_d.pop_front(), {d_s3, d_s2, d_s1, d_s0}, d_draws, d_fb);
        else                score("dflt", 1'b0, '{default: 0}, {d_s3, d_s2, d_s1, d_s0}, d_draws, d_fb);
      end
      if (n_ready && !n_rq) begin
        if (q_n.size() > 0) score("norep", 1'b1, q_n.pop_front(), {n_s3, n_s2, n_s1, n_s0}, n_draws, n_fb);
        else                score("norep", 1'b0, '{default: 0}, {n_s3, n_s2, n_s1, n_s0}, n_draws, n_fb);
      end
    end
  end

  task automatic set_prng(input logic [11:0] c);
    {p3, p2, p1, p0} = c;
  endtask

  task automatic start_game(output int e0);
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    new_game = 1'b0;
  endtask

  task automatic push(input int c, input logic [11:0] ds, input logic [3:0] dd, input logic df,
                      input logic [11:0] ns, input logic [3:0] nd, input logic nf);
    q_d.push_back('{cyc: c + 2 * int'(dd), sec: ds, draws: dd, fb: df});
    q_n.push_back('{cyc: c + 2 * int'(nd), sec: ns, draws: nd, fb: nf});
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 100 && (q_d.size() > 0 || q_n.size() > 0); k++) @(negedge clk);
    if (q_d.size() > 0 || q_n.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL commit_timeout: got %0d/%0d pending expected 0", q_d.size(), q_n.size());
      q_d.delete();
      q_n.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_dflt"}, {19'd0, d_s3, d_s2, d_s1, d_s0, d_ready, d_busy, d_draws, d_fb},
        32'd0);
    chk({name, "_norep"}, {19'd0, n_s3, n_s2, n_s1, n_s0, n_ready, n_busy, n_draws, n_fb},
        32'd0);
  endtask

  vec_t vt[7];

  initial begin
    int e0;
    vt[0] = '{c4(0,1,3,5), c4(0,1,3,5), 4'd1,  1'b0, c4(0,1,3,5), 4'd1,  1'b0};
    vt[1] = '{c4(7,6,2,0), c4(1,0,2,0), 4'd15, 1'b1, c4(3,2,1,0), 4'd15, 1'b1};
    vt[2] = '{c4(2,2,4,1), c4(2,2,4,1), 4'd1,  1'b0, c4(3,2,1,0), 4'd15, 1'b1};
    vt[3] = '{c4(5,5,5,5), c4(5,5,5,5), 4'd1,  1'b0, c4(3,2,1,0), 4'd15, 1'b1};
    vt[4] = '{c4(6,0,1,2), c4(0,0,1,2), 4'd15, 1'b1, c4(3,2,1,0), 4'd15, 1'b1};
    vt[5] = '{c4(5,4,3,2), c4(5,4,3,2), 4'd1,  1'b0, c4(5,4,3,2), 4'd1,  1'b0};
    vt[6] = '{c4(3,7,0,4), c4(3,1,0,4), 4'd15, 1'b1, c4(3,2,1,0), 4'd15, 1'b1};

    rst = 1'b1;
    new_game = 1'b0;
    set_prng(12'd0);
    repeat (2) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      set_prng(vt[i].code);
      start_game(e0);
      push(e0, vt[i].d_sec, vt[i].d_dr, vt[i].d_fb, vt[i].n_sec, vt[i].n_dr, vt[i].n_fb);
      wait_done();
    end
    chk("ready_level_hold", {31'd0, d_ready}, 32'd1);

    // Retry: illegal draw at E1, legal draw at E3
    set_prng(c4(7,1,2,3));
    start_game(e0);
    push(e0, c4(4,2,1,0), 4'd2, 1'b0, c4(4,2,1,0), 4'd2, 1'b0);
    @(posedge clk);
    #1 set_prng(c4(4,2,1,0));
    wait_done();

    // new_game while busy is neither accepted nor queued
    set_prng(c4(7,6,2,0));
    start_game(e0);
    push(e0, c4(1,0,2,0), 4'd15, 1'b1, c4(3,2,1,0), 4'd15, 1'b1);
    @(negedge clk);
    chk("busy_in_draw", {31'd0, d_busy}, 32'd1);
    new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("idle_after_busy_pulse", {31'd0, d_busy}, 32'd0);

    // new_game held: commits at E2, E5, E8
    set_prng(c4(0,1,3,5));
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    push(e0, c4(0,1,3,5), 4'd1, 1'b0, c4(0,1,3,5), 4'd1, 1'b0);
    push(e0 + 3, c4(0,1,3,5), 4'd1, 1'b0, c4(0,1,3,5), 4'd1, 1'b0);
    push(e0 + 6, c4(0,1,3,5), 4'd1, 1'b0, c4(0,1,3,5), 4'd1, 1'b0);
    repeat (8) @(posedge clk);
    #1 new_game = 1'b0;
    wait_done();

    // Asynchronous reset, not aligned to any clock edge
    @(negedge clk);
    #3 rst = 1'b1;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during a retrying draw aborts without commit
    set_prng(c4(6,0,1,2));
    start_game(e0);
    push(e0, c4(0,0,1,2), 4'd15, 1'b1, c4(3,2,1,0), 4'd15, 1'b1);
    wait_done();
    set_prng(c4(7,1,2,3));
    start_game(e0);
    repeat (3) @(posedge clk);
    #1 chk("draws_at_e3", {28'd0, d_draws}, 32'd2);
    rst = 1'b1;
    #1 chk_zero("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_commit", {30'd0, d_ready, n_ready}, 32'd0);
    chk("abort_idle", {30'd0, d_busy, n_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
